mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage: the consuming end of the execute stage's result and memory-request interface.
- Passes ALU results straight through to writeback.
- Converts load/store requests into a req/ack transaction on the data bus, stalls the pipeline until the bus completes, and returns load data as the writeback value.
- Sits between the execute stage and register-file writeback.

Parameters:
- TIMEOUT, 16, max cycles waiting for dbus_ack before aborting the access (≥2).
- TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- EX_x_rd_vld  in  1  ALU writeback valid from execute
- EX_x_rd  in  32  ALU writeback value
- EX_rd_idx  in  5  destination register index
- EX_MEMaddr  in  32  memory byte address
- EX_MEMrden  in  4  byte read enables (1111 = word load)
- EX_MEMwren  in  4  byte write enables (1111 = word store)
- EX_MEMwrdata  in  32  store data
- stall  out  1  hold upstream stages; execute keeps all EX_* stable while high
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word-aligned address
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  write data
- dbus_rdata  in  32  read data, valid with dbus_ack
- dbus_ack  in  1  one-cycle completion strobe
- MEM_x_rd_vld  out  1  writeback valid
- MEM_x_rd  out  32  writeback value
- MEM_rd_idx  out  5  writeback register index
- MEM_err  out  1  one-cycle fault pulse (misaligned, conflicting enables, timeout)

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Reset mid-access drops dbus_req immediately (asynchronous) and the transaction is abandoned.
- memreq = |EX_MEMrden | |EX_MEMwren.
- stall is combinational: (state==IDLE && memreq) || state==ACCESS.

FSM IDLE:
- No memreq: MEM_x_rd_vld<=EX_x_rd_vld, MEM_x_rd<=EX_x_rd, MEM_rd_idx<=EX_rd_idx, MEM_err<=0. Latency 1 cycle.
- memreq with both rden and wren nonzero → RESP with fault.
- memreq with word enable (1111) and addr[1:0]!=0 → RESP with fault.
- memreq with any other enable pattern → capture we=|wren, be=wren|rden, addr={addr[31:2],2'b00}, wdata, rd_idx; load=|rden. Go to ACCESS; MEM_x_rd_vld<=0.

FSM ACCESS:
- dbus_req=1; dbus_we, dbus_be, dbus_addr, dbus_wdata are held from the captured values.
- Counter increments every cycle.
- dbus_ack → latch dbus_rdata, go to RESP.
- Counter reaches TIMEOUT-1 without ack → go to RESP with fault. An ack arriving in that same cycle wins: no fault.

FSM RESP (one cycle, stall=0, so execute advances):
- MEM_x_rd_vld<=load && !fault; MEM_x_rd<=rdata; MEM_rd_idx<=captured idx; MEM_err<=fault.
- Clear the counter; go to IDLE.
- EX_* inputs are ignored in this cycle.

General rules:
- dbus_* outputs are 0 outside ACCESS.
- Stores never assert MEM_x_rd_vld.
- A fault suppresses writeback and issues no further bus traffic.
- Back-to-back memory requests: each costs at least 3 cycles (IDLE capture, ACCESS ≥1, RESP).

Test Plan:
- ALU passthrough: EX_x_rd_vld=1, EX_x_rd=0x0000_1234, rd_idx=5, no memreq → next cycle MEM_x_rd_vld=1, MEM_x_rd=0x1234, MEM_rd_idx=5; stall stays 0.
- Word load: rden=1111, addr=0x100, rd_idx=7; bus acks after 3 cycles with 0xDEADBEEF.
  - stall high from request until the ack cycle.
  - dbus_addr=0x100, dbus_be=1111, dbus_we=0.
  - Cycle after ack: MEM_x_rd=0xDEADBEEF, MEM_x_rd_vld=1, MEM_rd_idx=7.
- Word store: wren=1111, addr=0x204, wrdata=0xA5A5A5A5; ack after 1 cycle → dbus_we=1, dbus_wdata=0xA5A5A5A5, dbus_be=1111; MEM_x_rd_vld stays 0.
- Misaligned load: rden=1111, addr=0x102 → dbus_req never asserts; MEM_err pulses 1 cycle; no writeback.
- Timeout: load with ack withheld → dbus_req drops after exactly TIMEOUT cycles; MEM_err=1 for one cycle; stall releases.
  - Repeat with ack on cycle TIMEOUT-1 → normal completion, MEM_err=0.
- Reset mid-access: assert rst_n=0 during ACCESS → dbus_req, stall and MEM_* go to 0 immediately; after release, a new load completes normally.

Source files
------------

// File: rtl/mem_access.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | mem_access: memory stage - ALU passthrough, load/store bus handshake.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_x_rd_vld,
  input  logic [31:0] EX_x_rd,
  input  logic [4:0]  EX_rd_idx,
  input  logic [31:0] EX_MEMaddr,
  input  logic [3:0]  EX_MEMrden,
  input  logic [3:0]  EX_MEMwren,
  input  logic [31:0] EX_MEMwrdata,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        MEM_x_rd_vld,
  output logic [31:0] MEM_x_rd,
  output logic [4:0]  MEM_rd_idx,
  output logic        MEM_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TO_W-1:0] cnt;
  logic            cap_we;
  logic            cap_load;
  logic [3:0]      cap_be;
  logic [29:0]     cap_addr;
  logic [31:0]     cap_wdata;
  logic [4:0]      cap_idx;
  logic [31:0]     rdata_q;
  logic            fault;

  logic memreq;
  logic bad_req;
  logic timed_out;

  assign memreq    = (|EX_MEMrden) | (|EX_MEMwren);
  // Conflicting enables, or a full-word access that is not word aligned.
  assign bad_req   = ((|EX_MEMrden) && (|EX_MEMwren)) ||
                     (((EX_MEMrden == 4'hF) || (EX_MEMwren == 4'hF)) &&
                      (EX_MEMaddr[1:0] != 2'b00));
  assign timed_out = (cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = 32'd0;
    dbus_be    = 4'd0;
    dbus_wdata = 32'd0;
    case (state)
      IDLE: begin
        stall = rst_n && memreq;
        if (memreq) state_nx = bad_req ? RESP : ACCESS;
      end
      ACCESS: begin
        stall      = rst_n;
        dbus_req   = 1'b1;
        dbus_we    = cap_we;
        dbus_addr  = {cap_addr, 2'b00};
        dbus_be    = cap_be;
        dbus_wdata = cap_wdata;
        if (dbus_ack || timed_out) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      cap_we       <= 1'b0;
      cap_load     <= 1'b0;
      cap_be       <= 4'd0;
      cap_addr     <= 30'd0;
      cap_wdata    <= 32'd0;
      cap_idx      <= 5'd0;
      rdata_q      <= 32'd0;
      fault        <= 1'b0;
      MEM_x_rd_vld <= 1'b0;
      MEM_x_rd     <= 32'd0;
      MEM_rd_idx   <= 5'd0;
      MEM_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MEM_err <= 1'b0;
          if (!memreq) begin
            MEM_x_rd_vld <= EX_x_rd_vld;
            MEM_x_rd     <= EX_x_rd;
            MEM_rd_idx   <= EX_rd_idx;
          end else begin
            MEM_x_rd_vld <= 1'b0;
            fault        <= bad_req;
            cap_we       <= |EX_MEMwren;
            cap_load     <= |EX_MEMrden;
            cap_be       <= EX_MEMwren | EX_MEMrden;
            cap_addr     <= EX_MEMaddr[31:2];
            cap_wdata    <= EX_MEMwrdata;
            cap_idx      <= EX_rd_idx;
            cnt          <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          // An ack in the final counted cycle takes priority over the timeout.
          if (dbus_ack)       rdata_q <= dbus_rdata;
          else if (timed_out) fault   <= 1'b1;
        end
        RESP: begin
          MEM_x_rd_vld <= cap_load && !fault;
          MEM_x_rd     <= rdata_q;
          MEM_rd_idx   <= cap_idx;
          MEM_err      <= fault;
          cnt          <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | tb_mem_access: scoreboard bench with bus responder and reference model.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mem_access;
  localparam int TIMEOUT  = 16;
  localparam int WITHHOLD = TIMEOUT + 5;

  logic        clk, rst_n;
  logic        EX_x_rd_vld;
  logic [31:0] EX_x_rd;
  logic [4:0]  EX_rd_idx;
  logic [31:0] EX_MEMaddr;
  logic [3:0]  EX_MEMrden, EX_MEMwren;
  logic [31:0] EX_MEMwrdata;
  logic        stall, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic        MEM_x_rd_vld;
  logic [31:0] MEM_x_rd;
  logic [4:0]  MEM_rd_idx;
  logic        MEM_err;

  mem_access #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_x_rd_vld(EX_x_rd_vld), .EX_x_rd(EX_x_rd), .EX_rd_idx(EX_rd_idx),
    .EX_MEMaddr(EX_MEMaddr), .EX_MEMrden(EX_MEMrden), .EX_MEMwren(EX_MEMwren),
    .EX_MEMwrdata(EX_MEMwrdata), .stall(stall),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack), .MEM_x_rd_vld(MEM_x_rd_vld), .MEM_x_rd(MEM_x_rd),
    .MEM_rd_idx(MEM_rd_idx), .MEM_err(MEM_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        err;
    logic [31:0] data;
    logic [4:0]  idx;
  } wb_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    logic        alu_vld;
    logic [31:0] alu;
    logic [4:0]  idx;
    logic [31:0] addr;
    logic [3:0]  rden;
    logic [3:0]  wren;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } op_t;

  wb_t  exp_q[$];
  bus_t bus_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Writeback monitor
  wb_t mon_e;
  always @(negedge clk) begin
    if (rst_n && (MEM_x_rd_vld || MEM_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", {MEM_x_rd_vld, MEM_err, MEM_rd_idx, MEM_x_rd}, 128'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("writeback",
            {MEM_x_rd_vld, MEM_err, (MEM_x_rd_vld ? MEM_rd_idx : 5'd0), (MEM_x_rd_vld ? MEM_x_rd : 32'd0)},
            {mon_e.vld, mon_e.err, (mon_e.vld ? mon_e.idx : 5'd0), (mon_e.vld ? mon_e.data : 32'd0)});
      end
    end
  end

  // Bus responder: checks request fields and acks after the planned delay
  bus_t rb;
  int   rcnt;
  initial begin
    dbus_ack   = 1'b0;
    dbus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && dbus_req) begin
        if (bus_q.size() == 0) begin
          chk("spurious_req", {dbus_req, dbus_addr}, 128'd0);
        end else begin
          rb   = bus_q.pop_front();
          rcnt = 0;
          chk("bus_fields", {dbus_we, dbus_be, dbus_addr, dbus_wdata},
              {rb.we, rb.be, rb.addr, rb.wdata});
          forever begin
            if (rcnt == rb.delay) begin
              dbus_ack   = 1'b1;
              dbus_rdata = rb.rdata;
              @(posedge clk);
              #1;
              dbus_ack   = 1'b0;
              dbus_rdata = $urandom;
              break;
            end
            @(negedge clk);
            if (!rst_n) break;
            rcnt++;
            if (rcnt == TIMEOUT) begin
              chk("timeout_drop", {31'd0, dbus_req}, 128'd0);
              break;
            end
            chk("bus_hold", {dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata},
                {1'b1, rb.we, rb.be, rb.addr, rb.wdata});
          end
        end
      end
    end
  end

  function automatic op_t mk(input logic alu_vld, input logic [31:0] alu, input logic [4:0] idx,
                             input logic [31:0] addr, input logic [3:0] rden, input logic [3:0] wren,
                             input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
    op_t o;
    o.alu_vld = alu_vld; o.alu = alu; o.idx = idx; o.addr = addr;
    o.rden = rden; o.wren = wren; o.wdata = wdata; o.delay = delay; o.rdata = rdata;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t        o;
    int         kind, r;
    logic [3:0] pats [6];
    pats = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};
    o = mk($urandom_range(0, 1), $urandom, 5'($urandom), $urandom & 32'hFFFF_FFFC,
           4'd0, 4'd0, $urandom, 0, $urandom);
    r = $urandom_range(0, 9);
    if (r < 6)       o.delay = $urandom_range(0, 4);
    else if (r == 6) o.delay = TIMEOUT - 1;
    else if (r == 7) o.delay = TIMEOUT - 2;
    else             o.delay = WITHHOLD;
    kind = $urandom_range(0, 5);
    case (kind)
      1: o.rden = 4'hF;
      2: begin o.rden = pats[$urandom_range(0, 5)]; o.addr = $urandom; end
      3: o.wren = 4'($urandom_range(1, 15));
      4: begin o.rden = 4'($urandom_range(1, 15)); o.wren = 4'($urandom_range(1, 15)); end
      5: begin
           if ($urandom_range(0, 1) == 1) o.rden = 4'hF; else o.wren = 4'hF;
           o.addr = o.addr | 32'($urandom_range(1, 3));
         end
      default: ;
    endcase
    return o;
  endfunction

  // Reference model: derive expected writeback, bus access and stall length
  task automatic issue(input op_t o);
    logic [3:0] en;
    bit         fault, s, done;
    int         exp_stall, n;
    bus_t       b;
    wb_t        w;
    EX_x_rd_vld  = o.alu_vld;
    EX_x_rd      = o.alu;
    EX_rd_idx    = o.idx;
    EX_MEMaddr   = o.addr;
    EX_MEMrden   = o.rden;
    EX_MEMwren   = o.wren;
    EX_MEMwrdata = o.wdata;
    en    = o.rden | o.wren;
    fault = (o.rden != 0 && o.wren != 0) || (en == 4'hF && o.addr[1:0] != 2'b00);
    w.vld = 1'b0; w.err = 1'b0; w.data = 32'd0; w.idx = 5'd0;
    if (en == 0) begin
      exp_stall = 0;
      if (o.alu_vld) begin
        w.vld = 1'b1; w.data = o.alu; w.idx = o.idx;
        exp_q.push_back(w);
      end
    end else if (fault) begin
      exp_stall = 1;
      w.err = 1'b1;
      exp_q.push_back(w);
    end else begin
      b.we = (o.wren != 0); b.be = en; b.addr = o.addr & 32'hFFFF_FFFC;
      b.wdata = o.wdata; b.delay = o.delay; b.rdata = o.rdata;
      bus_q.push_back(b);
      if (o.delay < TIMEOUT) begin
        exp_stall = o.delay + 2;
        if (o.rden != 0) begin
          w.vld = 1'b1; w.data = o.rdata; w.idx = o.idx;
          exp_q.push_back(w);
        end
      end else begin
        exp_stall = TIMEOUT + 1;
        w.err = 1'b1;
        exp_q.push_back(w);
      end
    end
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 4 * TIMEOUT + 8; k++) begin
      @(negedge clk);
      s = stall;
      if (s) n++;
      @(posedge clk);
      #1;
      if (!s) begin done = 1'b1; break; end
    end
    chk("stall_cycles", {done, 32'(n)}, {1'b1, 32'(exp_stall)});
  endtask

  task automatic drive_idle();
    EX_x_rd_vld = 1'b0; EX_x_rd = 32'd0; EX_rd_idx = 5'd0; EX_MEMaddr = 32'd0;
    EX_MEMrden = 4'd0; EX_MEMwren = 4'd0; EX_MEMwrdata = 32'd0;
  endtask

  initial begin
    bus_t rstb;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {stall, dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata,
                        MEM_x_rd_vld, MEM_err, MEM_rd_idx, MEM_x_rd}, 128'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(mk(1'b1, 32'h0000_1234, 5'd5, 32'd0, 4'h0, 4'h0, 32'd0, 0, 32'd0));
    issue(mk(1'b0, 32'd0, 5'd7, 32'h100, 4'hF, 4'h0, 32'd0, 3, 32'hDEAD_BEEF));
    issue(mk(1'b0, 32'd0, 5'd3, 32'h204, 4'h0, 4'hF, 32'hA5A5_A5A5, 1, 32'h1111_1111));
    issue(mk(1'b0, 32'd0, 5'd9, 32'h102, 4'hF, 4'h0, 32'd0, 0, 32'd0));
    issue(mk(1'b0, 32'd0, 5'd4, 32'h180, 4'hF, 4'h0, 32'd0, WITHHOLD, 32'h2222_2222));
    issue(mk(1'b0, 32'd0, 5'd6, 32'h184, 4'hF, 4'h0, 32'd0, TIMEOUT - 1, 32'h3333_3333));
    issue(mk(1'b1, 32'hCAFE_0001, 5'd1, 32'h0, 4'h3, 4'h1, 32'd0, 0, 32'd0));
    issue(mk(1'b1, 32'h0BAD_F00D, 5'd31, 32'd0, 4'h0, 4'h0, 32'd0, 0, 32'd0));

    for (int i = 0; i < 150; i++) issue(rand_op());

    // Reset while an access is outstanding
    EX_x_rd_vld = 1'b0; EX_rd_idx = 5'd12; EX_MEMaddr = 32'h300;
    EX_MEMrden = 4'hF; EX_MEMwren = 4'h0;
    rstb.we = 1'b0; rstb.be = 4'hF; rstb.addr = 32'h300; rstb.wdata = EX_MEMwrdata;
    rstb.delay = 1000; rstb.rdata = 32'd0;
    bus_q.push_back(rstb);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_access", {stall, dbus_req, MEM_x_rd_vld, MEM_err, MEM_rd_idx, MEM_x_rd}, 128'd0);
    bus_q.delete();
    exp_q.delete();
    drive_idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(mk(1'b0, 32'd0, 5'd13, 32'h304, 4'hF, 4'h0, 32'd0, 2, 32'h5A5A_0F0F));

    drive_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("queues_drained", {32'(exp_q.size()), 32'(bus_q.size())}, 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
